// File: rtl/array_match_pkg.sv
// array_match_pkg: shared slot state type and parameter sanity helper for the CAM
package array_match_pkg;
    typedef enum logic {EMPTY, FULL} slot_e;
    function automatic bit params_ok(input int size, input int width);
        return size >= 2 && width >= 1;
    endfunction
endpackage

// File: rtl/array_match_prienc.sv
// array_match_prienc: match mask to hit flag, lowest set index and population count
module array_match_prienc #(
    parameter int SIZE = 8,
    localparam int IDX_W = $clog2(SIZE),
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic [SIZE-1:0]  mask,
    output logic             hit,
    output logic [IDX_W-1:0] index,
    output logic [CNT_W-1:0] count
);
    always_comb begin
        hit = |mask;
        index = '0;
        count = '0;
        // Descending scan so the lowest set bit is the last one written
        for (int i = SIZE - 1; i >= 0; i--) begin
            index = mask[i] ? IDX_W'(i) : index;
            count = count + CNT_W'(mask[i]);
        end
    end
endmodule

// File: rtl/array_match_cam.sv
// array_match_cam: ternary-search CAM with single-slot registered result and valid/ready handshakes
module array_match_cam import array_match_pkg::*; #(
    parameter int SIZE = 8,
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(SIZE),
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_set,
    input  logic             search_valid,
    output logic             search_ready,
    input  logic [WIDTH-1:0] search_key,
    input  logic [WIDTH-1:0] search_care,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SIZE-1:0]  res_mask,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_index,
    output logic [CNT_W-1:0] res_count
);
    if (!params_ok(SIZE, WIDTH)) begin : g_bad_params
        $error("array_match_cam: SIZE must be >= 2 and WIDTH >= 1");
    end

    slot_e            state_q, state_d;
    logic [WIDTH-1:0] entry_q [SIZE];
    logic [WIDTH-1:0] entry_d [SIZE];
    logic [SIZE-1:0]  valid_q, valid_d, match, mask_q, mask_d;
    logic             hit, hit_q, hit_d, accept, wr_ok;
    logic [IDX_W-1:0] idx, idx_q, idx_d;
    logic [CNT_W-1:0] cnt, cnt_q, cnt_d;

    assign search_ready = state_q == EMPTY || res_ready;
    assign accept = search_valid && search_ready;
    assign wr_ok = wr_en && 32'(wr_addr) < SIZE;

    always_comb begin
        for (int i = 0; i < SIZE; i++)
            match[i] = valid_q[i] && ((entry_q[i] ^ search_key) & search_care) == '0;
    end

    array_match_prienc #(.SIZE(SIZE)) u_prienc (
        .mask  (match),
        .hit   (hit),
        .index (idx),
        .count (cnt)
    );

    // Search reads the _q arrays, so a same-cycle write is not visible to it
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (wr_ok) begin
            valid_d[wr_addr] = wr_set;
            entry_d[wr_addr] = wr_set ? wr_data : entry_q[wr_addr];
        end
        state_d = accept ? FULL : (res_ready ? EMPTY : state_q);
        mask_d = accept ? match : mask_q;
        hit_d = accept ? hit : hit_q;
        idx_d = accept ? idx : idx_q;
        cnt_d = accept ? cnt : cnt_q;
    end

    always_ff @(posedge clk) entry_q <= entry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            valid_q <= '0;
            mask_q <= '0;
            hit_q <= 1'b0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            mask_q <= mask_d;
            hit_q <= hit_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign res_valid = state_q == FULL;
    assign res_mask = mask_q;
    assign res_hit = hit_q;
    assign res_index = idx_q;
    assign res_count = cnt_q;
endmodule
